// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - dumps a register file pairwise over a valid/ready stream
// Optional running checksum output enabled by REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              busy,
  output logic              done
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, SEND_A, SEND_B, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_REGS / 2 - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] k_issue;
  logic [DATA_W-1:0] buf_a, buf_b;

  // Pair index that the next ISSUE state will present to the register file.
  assign k_issue = (state_q == IDLE) ? '0 : k_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_addr  = '0;
    case (state_q)
      IDLE:   if (start) state_d = ISSUE;
      ISSUE:  state_d = CAPT;
      CAPT:   state_d = SEND_A;
      SEND_A: begin
        dump_valid = 1'b1;
        dump_data  = buf_a;
        dump_addr  = {k_q[ADDR_W-2:0], 1'b0};
        if (dump_ready) state_d = SEND_B;
      end
      SEND_B: begin
        dump_valid = 1'b1;
        dump_data  = buf_b;
        dump_addr  = {k_q[ADDR_W-2:0], 1'b1};
        if (dump_ready) state_d = (k_q == LAST_K) ? DONE : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      buf_a   <= '0;
      buf_b   <= '0;
      rs      <= '0;
      rt      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        k_q <= '0;
      else if (state_q == SEND_B && dump_ready)
        k_q <= k_q + ADDR_W'(1);
      // Addresses are registered on entry to ISSUE so they are stable for the whole state.
      if (state_d == ISSUE && state_q != ISSUE) begin
        rs <= {k_issue[ADDR_W-2:0], 1'b0};
        rt <= {k_issue[ADDR_W-2:0], 1'b1};
      end
      if (state_q == CAPT) begin
        buf_a <= a;
        buf_b <= b;
      end
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      checksum <= '0;
    else if (state_q == IDLE && start)
      checksum <= '0;
    else if (dump_valid && dump_ready)
      checksum <= checksum + dump_data;
  end
`endif

endmodule
